// File: rtl/safev_pkg.sv
// Shared definitions for the SAFEV core front end.
// Contents:
//   XLEN               - architectural register and address width
//   RESET_PC_DEFAULT   - default program counter after reset
//   NOP_INSTR_DEFAULT  - canonical bubble instruction (addi x0,x0,0)
//   fetch_state_e      - fetch stage state encoding
//   word_align()       - clears the byte-offset bits of an address
package safev_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Instructions are always 4-byte aligned, so redirect targets drop bits [1:0].
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/safev_if_id_reg.sv
// One-entry pipeline slot carrying a fetched instruction to decode.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   load               - capture load_instr/load_pc into the slot
//   consume            - downstream took the slot (ignored when load or flush)
//   flush              - drop the slot contents and show a bubble
//   load_instr,load_pc - incoming instruction word and its address
//   valid,instr,pc,pc4 - slot contents; pc4 is pc+4 for link registers
module safev_if_id_reg
  import safev_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            consume,
  input  logic            flush,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4
);

  // Flush wins over everything so a wrong-path instruction never survives;
  // a load at the same edge as a consume simply replaces the drained entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
      pc4   <= load_pc + 32'd4;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/safev_fetch.sv
// Instruction-fetch stage of the SAFEV RISC-V core.
// Owns the PC, runs a req/ack instruction-memory handshake with variable
// latency, and presents fetched words to decode through a one-entry slot.
// Ports:
//   CLOCK_50, reset_n        - core clock, asynchronous active-low reset
//   imem_req, imem_addr      - fetch request, held until imem_ack
//   imem_ack, imem_rdata     - single-cycle response strobe and data
//   redirect, redirect_pc    - PC change request from execute
//   hlt                      - decode reports a halt instruction in the slot
//   id_ready                 - decode accepts the slot this cycle
//   id_valid, id_instr,
//   id_pc, id_pc4            - slot contents towards decode
//   halted                   - fetch has stopped until reset
module safev_fetch
  import safev_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            hlt,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic            halted
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic            squash;

  logic launch;
  logic accept;
  logic take_redirect;
  logic slot_flush;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Redirect outranks hlt because a halt seen alongside a
  // redirect is on the wrong path. An outstanding request always runs to
  // its ack before the stage is allowed to stop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (redirect)                      state_next = IDLE;
        else if (hlt)                      state_next = HALT;
        else if (!id_valid || id_ready)    state_next = REQ;
      end
      REQ: begin
        if (imem_ack) state_next = (hlt && !redirect) ? HALT : IDLE;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Control decode. A response is only kept when nothing has made it stale:
  // no earlier redirect (squash), no redirect now, and no pending halt.
  // Entering HALT also empties the slot so decode sees no valid instruction.
  always_comb begin
    launch        = (state == IDLE) && (state_next == REQ);
    accept        = (state == REQ) && imem_ack && !squash && !redirect && !hlt;
    take_redirect = redirect && (state != HALT);
    slot_flush    = take_redirect || ((state != HALT) && (state_next == HALT));
  end

  assign imem_req = (state == REQ);
  assign halted   = (state == HALT);

  // PC, squash flag and the latched request address. Squash marks the
  // in-flight response as dead when a redirect arrives before its ack.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      squash    <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      if (take_redirect)  pc <= word_align(redirect_pc);
      else if (accept)    pc <= pc + 32'd4;

      if ((state == REQ) && imem_ack)    squash <= 1'b0;
      else if (take_redirect && (state == REQ)) squash <= 1'b1;

      if (launch) imem_addr <= pc;
    end
  end

  safev_if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_slot (
    .clk       (CLOCK_50),
    .rst_n     (reset_n),
    .load      (accept),
    .consume   (id_valid && id_ready),
    .flush     (slot_flush),
    .load_instr(imem_rdata),
    .load_pc   (pc),
    .valid     (id_valid),
    .instr     (id_instr),
    .pc        (id_pc),
    .pc4       (id_pc4)
  );

endmodule

// File: tb/tb_safev_fetch.sv
// Directed testbench for safev_fetch. Inputs are driven and outputs sampled
// 1 time unit after each rising clock edge; memory responses are issued by
// hand so ack latency and redirect timing can be placed exactly.
module tb_safev_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hlt;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        halted;

  int assertions = 0;
  int failures   = 0;

  safev_fetch dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .hlt        (hlt),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .halted     (halted)
  );

  // 10-unit clock period.
  always #5 CLOCK_50 = ~CLOCK_50;

  // Distinct, easily recognised instruction word for each address.
  function automatic logic [31:0] instrAt(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ addr;
  endfunction

  // Advance to 1 unit after the next rising edge.
  task automatic waitCycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Drive every DUT input in one go.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic redir, input logic [31:0] rpc,
                               input logic halt_in, input logic ready);
    imem_ack    = ack;
    imem_rdata  = rdata;
    redirect    = redir;
    redirect_pc = rpc;
    hlt         = halt_in;
    id_ready    = ready;
  endtask

  // One comparison against a hand-computed value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Present a 1-cycle ack with the word for addr, then return inputs to idle.
  task automatic ackWord(input logic [31:0] addr, input logic halt_in);
    applyStimulus(1'b1, instrAt(addr), 1'b0, 32'h0, halt_in, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, halt_in, 1'b1);
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    repeat (2) waitCycle();

    // Reset state.
    checkOutput("rst_req",    imem_req, 0);
    checkOutput("rst_valid",  id_valid, 0);
    checkOutput("rst_instr",  id_instr, NOP);
    checkOutput("rst_pc",     id_pc,    0);
    checkOutput("rst_pc4",    id_pc4,   0);
    checkOutput("rst_halted", halted,   0);

    // First fetch from RESET_PC with 1-cycle latency.
    reset_n = 1'b1;
    waitCycle();
    checkOutput("f0_req",  imem_req,  1);
    checkOutput("f0_addr", imem_addr, 32'h0);
    ackWord(32'h0, 1'b0);
    checkOutput("f0_valid", id_valid, 1);
    checkOutput("f0_pc",    id_pc,    32'h0);
    checkOutput("f0_pc4",   id_pc4,   32'h4);
    checkOutput("f0_instr", id_instr, instrAt(32'h0));
    checkOutput("f0_req_lo", imem_req, 0);

    // Backpressure: slot holds, no new request.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      waitCycle();
      checkOutput("bp_valid", id_valid, 1);
      checkOutput("bp_pc",    id_pc,    32'h0);
      checkOutput("bp_req",   imem_req, 0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    waitCycle();
    checkOutput("f4_req",   imem_req,  1);
    checkOutput("f4_addr",  imem_addr, 32'h4);
    checkOutput("f4_drain", id_valid,  0);
    ackWord(32'h4, 1'b0);
    checkOutput("f4_pc",    id_pc,    32'h4);
    checkOutput("f4_pc4",   id_pc4,   32'h8);

    // Redirect while a 3-cycle-latency request to 0x8 is outstanding.
    waitCycle();
    checkOutput("f8_addr", imem_addr, 32'h8);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("sq_valid", id_valid,  0);
    checkOutput("sq_instr", id_instr,  NOP);
    checkOutput("sq_req",   imem_req,  1);
    checkOutput("sq_addr",  imem_addr, 32'h8);
    waitCycle();
    checkOutput("sq_hold",  imem_req,  1);
    ackWord(32'h8, 1'b0);
    checkOutput("sq_drop_valid", id_valid, 0);
    checkOutput("sq_drop_req",   imem_req, 0);
    waitCycle();
    checkOutput("t100_addr", imem_addr, 32'h100);
    ackWord(32'h100, 1'b0);
    checkOutput("t100_valid", id_valid, 1);
    checkOutput("t100_pc",    id_pc,    32'h100);
    checkOutput("t100_pc4",   id_pc4,   32'h104);
    checkOutput("t100_instr", id_instr, instrAt(32'h100));

    // Redirect coincident with ack; unaligned target is word-aligned.
    waitCycle();
    checkOutput("c104_addr", imem_addr, 32'h104);
    applyStimulus(1'b1, instrAt(32'h104), 1'b1, 32'h203, 1'b0, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("co_valid", id_valid, 0);
    checkOutput("co_req",   imem_req, 0);
    waitCycle();
    checkOutput("t200_addr", imem_addr, 32'h200);
    ackWord(32'h200, 1'b0);
    checkOutput("t200_valid", id_valid, 1);
    checkOutput("t200_pc",    id_pc,    32'h200);

    // Redirect and hlt together: no halt, fetch resumes at the target.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("rh_halted", halted,   0);
    checkOutput("rh_valid",  id_valid, 0);
    checkOutput("rh_req",    imem_req, 0);
    waitCycle();
    checkOutput("t300_addr", imem_addr, 32'h300);
    checkOutput("t300_req",  imem_req,  1);
    ackWord(32'h300, 1'b0);
    checkOutput("t300_pc", id_pc, 32'h300);

    // hlt with a request outstanding: request completes, then HALT.
    waitCycle();
    checkOutput("h304_addr", imem_addr, 32'h304);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    waitCycle();
    checkOutput("h_hold_req", imem_req, 1);
    checkOutput("h_not_yet",  halted,   0);
    ackWord(32'h304, 1'b1);
    checkOutput("h_halted", halted,   1);
    checkOutput("h_req",    imem_req, 0);
    checkOutput("h_valid",  id_valid, 0);
    repeat (3) waitCycle();
    checkOutput("h_stay_halted", halted,   1);
    checkOutput("h_stay_req",    imem_req, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    waitCycle();
    checkOutput("h_terminal", halted, 1);

    // Asynchronous reset out of HALT.
    reset_n = 1'b0;
    #1;
    checkOutput("ar_halted", halted, 0);
    reset_n = 1'b1;
    waitCycle();
    checkOutput("ar_req",  imem_req,  1);
    checkOutput("ar_addr", imem_addr, 32'h0);
    waitCycle();

    // Asynchronous reset mid-request, then a stale ack while IDLE.
    reset_n = 1'b0;
    #1;
    checkOutput("mr_req",    imem_req, 0);
    checkOutput("mr_valid",  id_valid, 0);
    checkOutput("mr_instr",  id_instr, NOP);
    checkOutput("mr_pc",     id_pc,    0);
    applyStimulus(1'b1, instrAt(32'h0), 1'b0, 32'h0, 1'b0, 1'b1);
    waitCycle();
    reset_n = 1'b1;
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("st_valid", id_valid,  0);
    checkOutput("st_req",   imem_req,  1);
    checkOutput("st_addr",  imem_addr, 32'h0);
    waitCycle();
    checkOutput("st_still_req", imem_req, 1);
    ackWord(32'h0, 1'b0);
    checkOutput("st_pc", id_pc, 32'h0);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    waitCycle();
    checkOutput("wr_addr", imem_addr, 32'hFFFF_FFFC);
    ackWord(32'hFFFF_FFFC, 1'b0);
    checkOutput("wr_pc",  id_pc,  32'hFFFF_FFFC);
    checkOutput("wr_pc4", id_pc4, 32'h0);
    waitCycle();
    checkOutput("wr_next_req",  imem_req,  1);
    checkOutput("wr_next_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
